// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types, constants and width helpers for the HUB75 scan path
package hub75_pkg;

    // Scan sequencer states, in the order one bit plane walks through them
    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE,
        BLANK,
        DISPLAY,
        NEXT
    } scan_state_t;

    localparam int unsigned blank_cycles_dflt_c = 4;
    localparam int unsigned oe_base_w_c         = 8;

    // Index width for a count of n items; never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Display counter width: largest weight is 2^oe_base_w_c << (bpp-1)
    function automatic int unsigned disp_w(input int unsigned bpp);
        return oe_base_w_c + bpp;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// rtl/hub75_bcm_timer.sv - down-counter for blanking gaps and BCM-weighted display slots
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int unsigned disp_w_p = 16,
    parameter int unsigned bit_w_p  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_blank_i,
    input  logic [disp_w_p-1:0]    blank_val_i,
    input  logic                   load_bcm_i,
    input  logic [oe_base_w_c-1:0] base_i,
    input  logic [bit_w_p-1:0]     bit_i,
    output logic                   done_o
);

    logic [disp_w_p-1:0] cnt_q;
    logic [disp_w_p-1:0] cnt_d;

    // Load either the blank length or (base+1)<<bit, otherwise count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_blank_i) begin
            cnt_d = blank_val_i;
        end else if (load_bcm_i) begin
            cnt_d = (disp_w_p'(base_i) + disp_w_p'(1)) << bit_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - disp_w_p'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N keeps the owning state for N cycles; the last one sees cnt_q==1
    assign done_o = (cnt_q <= disp_w_p'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - row/bit-plane scan sequencer with BCM output-enable timing
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned hpixel_p       = 64,
    parameter int unsigned vpixel_p       = 64,
    parameter int unsigned bpp_p          = 8,
    parameter int unsigned segments_p     = 2,
    parameter int unsigned blank_cycles_p = blank_cycles_dflt_c,
    localparam int unsigned rows_p          = vpixel_p / segments_p,
    localparam int unsigned row_w_p         = idx_w(rows_p),
    localparam int unsigned addr_width_p    = idx_w(hpixel_p * vpixel_p),
    localparam int unsigned pix_bit_width_p = idx_w(bpp_p),
    localparam int unsigned disp_w_p        = disp_w(bpp_p)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_enable,
    input  logic [7:0]                 i_oe_base,
    output logic                       o_tx_start,
    output logic [addr_width_p-1:0]    o_init_addr,
    output logic [pix_bit_width_p-1:0] o_pix_bit,
    input  logic                       i_tx_ready,
    output logic [row_w_p-1:0]         o_row_addr,
    output logic                       o_oe_n,
    output logic                       o_frame_done,
    output logic                       o_busy
);

    scan_state_t state_q, state_d;

    logic [row_w_p-1:0]         row_cnt_q, row_cnt_d;
    logic [pix_bit_width_p-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]                 oe_base_q, oe_base_d;

    logic                       tx_start_q, tx_start_d;
    logic [addr_width_p-1:0]    init_addr_q, init_addr_d;
    logic [pix_bit_width_p-1:0] pix_bit_q, pix_bit_d;
    logic [row_w_p-1:0]         row_addr_q, row_addr_d;
    logic                       oe_n_q, oe_n_d;
    logic                       frame_done_q, frame_done_d;
    logic                       busy_q, busy_d;

    logic last_bit, last_row, frame_wrap;
    logic tmr_load_blank, tmr_load_bcm, tmr_done;

    assign last_bit   = (bit_cnt_q == pix_bit_width_p'(bpp_p - 1));
    assign last_row   = (row_cnt_q == row_w_p'(rows_p - 1));
    assign frame_wrap = last_bit && last_row;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; timer loads fire on the edge that enters BLANK / DISPLAY
    always_comb begin
        state_d        = state_q;
        tmr_load_blank = 1'b0;
        tmr_load_bcm   = 1'b0;
        case (state_q)
            IDLE:      if (i_enable && i_tx_ready) state_d = START;
            START:     state_d = WAIT_ACK;
            WAIT_ACK:  if (!i_tx_ready) state_d = WAIT_DONE;
            WAIT_DONE: if (i_tx_ready) begin
                           state_d        = BLANK;
                           tmr_load_blank = 1'b1;
                       end
            BLANK:     if (tmr_done) begin
                           state_d      = DISPLAY;
                           tmr_load_bcm = 1'b1;
                       end
            DISPLAY:   if (tmr_done) state_d = NEXT;
            NEXT:      state_d = (!i_enable && frame_wrap) ? IDLE : START;
            default:   state_d = IDLE;
        endcase
    end

    // Row/bit counters and BCM base; the base only moves at frame boundaries
    always_comb begin
        row_cnt_d = row_cnt_q;
        bit_cnt_d = bit_cnt_q;
        oe_base_d = oe_base_q;
        if (state_q == IDLE && state_d == START) begin
            row_cnt_d = '0;
            bit_cnt_d = '0;
            oe_base_d = i_oe_base;
        end else if (state_q == NEXT) begin
            if (!last_bit) begin
                bit_cnt_d = bit_cnt_q + pix_bit_width_p'(1);
            end else begin
                bit_cnt_d = '0;
                row_cnt_d = last_row ? '0 : row_cnt_q + row_w_p'(1);
            end
            if (frame_wrap) begin
                oe_base_d = i_oe_base;
            end
        end
    end

    // Output next-state, derived from the state being entered so outputs stay registered
    always_comb begin
        tx_start_d  = (state_d == START);
        init_addr_d = init_addr_q;
        pix_bit_d   = pix_bit_q;
        if (state_d == START) begin
            init_addr_d = addr_width_p'(row_cnt_d) * addr_width_p'(hpixel_p);
            pix_bit_d   = bit_cnt_d;
        end
        row_addr_d = row_addr_q;
        if (state_d == BLANK && state_q != BLANK) begin
            row_addr_d = row_cnt_q;
        end
        oe_n_d       = (state_d != DISPLAY);
        frame_done_d = (state_q == DISPLAY) && (state_d == NEXT) && frame_wrap;
        busy_d       = (state_d != IDLE);
    end

    // Datapath and output registers; reset blanks the panel immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            oe_base_q    <= '0;
            tx_start_q   <= 1'b0;
            init_addr_q  <= '0;
            pix_bit_q    <= '0;
            row_addr_q   <= '0;
            oe_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            row_cnt_q    <= row_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            oe_base_q    <= oe_base_d;
            tx_start_q   <= tx_start_d;
            init_addr_q  <= init_addr_d;
            pix_bit_q    <= pix_bit_d;
            row_addr_q   <= row_addr_d;
            oe_n_q       <= oe_n_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    hub75_bcm_timer #(
        .disp_w_p (disp_w_p),
        .bit_w_p  (pix_bit_width_p)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_blank_i (tmr_load_blank),
        .blank_val_i  (disp_w_p'(blank_cycles_p)),
        .load_bcm_i   (tmr_load_bcm),
        .base_i       (oe_base_q),
        .bit_i        (bit_cnt_q),
        .done_o       (tmr_done)
    );

    assign o_tx_start   = tx_start_q;
    assign o_init_addr  = init_addr_q;
    assign o_pix_bit    = pix_bit_q;
    assign o_row_addr   = row_addr_q;
    assign o_oe_n       = oe_n_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb/tb_hub75_scan_ctrl.sv - self-checking bench for hub75_scan_ctrl with a tx model
module tb_hub75_scan_ctrl;

    localparam int HPIX  = 4;
    localparam int VPIX  = 4;
    localparam int BPP   = 2;
    localparam int SEGS  = 2;
    localparam int BLANK = 4;
    localparam int ROWS  = VPIX / SEGS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_enable;
    logic [7:0] i_oe_base;
    logic       i_tx_ready = 1'b1;
    logic       o_tx_start;
    logic [3:0] o_init_addr;
    logic [0:0] o_pix_bit;
    logic [0:0] o_row_addr;
    logic       o_oe_n;
    logic       o_frame_done;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hub75_scan_ctrl #(
        .hpixel_p       (HPIX),
        .vpixel_p       (VPIX),
        .bpp_p          (BPP),
        .segments_p     (SEGS),
        .blank_cycles_p (BLANK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .i_oe_base    (i_oe_base),
        .o_tx_start   (o_tx_start),
        .o_init_addr  (o_init_addr),
        .o_pix_bit    (o_pix_bit),
        .i_tx_ready   (i_tx_ready),
        .o_row_addr   (o_row_addr),
        .o_oe_n       (o_oe_n),
        .o_frame_done (o_frame_done),
        .o_busy       (o_busy)
    );

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // tx model: ready drops 1..3 cycles after a start, stays low 2..8 cycles
    always begin
        @(posedge clk);
        #1;
        if (rst_n && o_tx_start) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 i_tx_ready = 1'b0;
            repeat ($urandom_range(2, 8)) @(posedge clk);
            #1 i_tx_ready = 1'b1;
        end
    end

    // Reference model: plane order is row-major over bits, weight (base+1)<<bit,
    // base taken at each frame's first plane, blank gap of BLANK cycles after tx done.
    int exp_row = 0, exp_bit = 0, cur_row = 0, cur_bit = 0, frame_base = 0;
    int phase = 0, gap = 0, low_cnt = 0, fd_count = 0;
    bit prev_oe_n = 1'b1, prev_start = 1'b0, oe_rise;
    int disp_len_log[$];
    int start_addr_log[$];
    int start_bit_log[$];
    int gap_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_row = 0; exp_bit = 0; cur_row = 0; cur_bit = 0;
            phase = 0; gap = 0; low_cnt = 0;
            prev_oe_n = 1'b1; prev_start = 1'b0;
        end else begin
            oe_rise = !prev_oe_n && o_oe_n;
            chk_eq("frame_done", int'(o_frame_done),
                   int'(oe_rise && cur_row == ROWS - 1 && cur_bit == BPP - 1));
            if (o_frame_done) fd_count++;
            if (oe_rise) begin
                chk_eq("disp_len", low_cnt, (frame_base + 1) << cur_bit);
                disp_len_log.push_back(low_cnt);
                low_cnt = 0;
            end
            if (o_tx_start) begin
                chk_eq("start_width", int'(prev_start), 0);
                chk_eq("busy_at_start", int'(o_busy), 1);
                chk_eq("oe_off_at_start", int'(o_oe_n), 1);
                if (exp_row == 0 && exp_bit == 0) frame_base = int'(i_oe_base);
                chk_eq("init_addr", int'(o_init_addr), exp_row * HPIX);
                chk_eq("pix_bit", int'(o_pix_bit), exp_bit);
                start_addr_log.push_back(int'(o_init_addr));
                start_bit_log.push_back(int'(o_pix_bit));
                cur_row = exp_row;
                cur_bit = exp_bit;
                if (exp_bit == BPP - 1) begin
                    exp_bit = 0;
                    exp_row = (exp_row + 1) % ROWS;
                end else begin
                    exp_bit++;
                end
                phase = 1;
            end
            if (phase == 1 && !i_tx_ready) begin
                phase = 2;
            end else if (phase == 2 && i_tx_ready) begin
                phase = 3;
                gap = 1;
                chk_eq("addr_hold", int'(o_init_addr), cur_row * HPIX);
                chk_eq("bit_hold", int'(o_pix_bit), cur_bit);
            end else if (phase == 3 && o_oe_n) begin
                gap++;
            end
            if (prev_oe_n && !o_oe_n) begin
                chk_eq("oe_after_shift", phase, 3);
                chk_eq("blank_gap", gap, BLANK + 1);
                gap_log.push_back(gap);
                phase = 0;
            end
            if (!o_oe_n) begin
                low_cnt++;
                chk_eq("row_addr_in_display", int'(o_row_addr), cur_row);
            end
            prev_oe_n  = o_oe_n;
            prev_start = o_tx_start;
        end
    end

    task automatic wait_starts(input int n);
        int t = 0;
        while (start_addr_log.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk_eq("start_wait", int'(start_addr_log.size() >= n), 1);
    endtask

    task automatic wait_disp(input int n);
        int t = 0;
        while (disp_len_log.size() < n && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk_eq("disp_wait", int'(disp_len_log.size() >= n), 1);
    endtask

    initial begin
        int exp_len[6]  = '{4, 8, 4, 8, 1, 2};
        int exp_addr[6] = '{0, 0, 4, 4, 0, 0};
        int exp_pb[6]   = '{0, 1, 0, 1, 0, 1};
        int n0, fd0, t, last;
        bit found;

        rst_n = 1'b0; i_enable = 1'b0; i_oe_base = 8'd3;
        repeat (3) @(negedge clk);
        chk_eq("rst_oe_n", int'(o_oe_n), 1);
        chk_eq("rst_tx_start", int'(o_tx_start), 0);
        chk_eq("rst_row_addr", int'(o_row_addr), 0);
        chk_eq("rst_busy", int'(o_busy), 0);
        chk_eq("rst_frame_done", int'(o_frame_done), 0);
        chk_eq("rst_init_addr", int'(o_init_addr), 0);
        chk_eq("rst_pix_bit", int'(o_pix_bit), 0);
        rst_n = 1'b1;
        @(negedge clk);
        i_enable = 1'b1;

        // Directed frame with base 3, then base 0 applied only at the wrap
        wait_starts(3);
        i_oe_base = 8'd0;
        wait_disp(6);
        foreach (exp_len[i]) begin
            if (i < disp_len_log.size()) chk_eq("lit_disp_len", disp_len_log[i], exp_len[i]);
            if (i < start_addr_log.size()) chk_eq("lit_start_addr", start_addr_log[i], exp_addr[i]);
            if (i < start_bit_log.size()) chk_eq("lit_start_bit", start_bit_log[i], exp_pb[i]);
        end
        if (gap_log.size() > 0) chk_eq("lit_blank_gap", gap_log[0], 5);
        chk_eq("lit_frame_done_count", fd_count, 1);

        // Random weights, changed only away from frame starts
        for (int k = 0; k < 24; k++) begin
            wait_starts(start_addr_log.size() + 1);
            last = start_addr_log.size() - 1;
            if (!(start_addr_log[last] == 0 && start_bit_log[last] == 0) && $urandom_range(0, 1) == 1)
                i_oe_base = 8'($urandom_range(0, 5));
        end

        // Disable during row 0: frame completes, then idle
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            wait_starts(start_addr_log.size() + 1);
            last = start_addr_log.size() - 1;
            found = (start_addr_log[last] == 0 && start_bit_log[last] == 0);
        end
        i_enable = 1'b0;
        n0  = start_addr_log.size();
        fd0 = fd_count;
        t = 0;
        while (fd_count == fd0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk_eq("disable_frame_done", int'(fd_count > fd0), 1);
        chk_eq("disable_remaining_starts", start_addr_log.size() - n0, 3);
        repeat (40) @(negedge clk);
        chk_eq("disable_no_more_starts", start_addr_log.size() - n0, 3);
        chk_eq("disable_busy", int'(o_busy), 0);
        chk_eq("disable_oe_n", int'(o_oe_n), 1);

        // Async reset during row 1 display
        i_oe_base = 8'd7;
        i_enable  = 1'b1;
        t = 0;
        while (!(o_oe_n == 1'b0 && o_row_addr == 1'b1) && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk_eq("reach_row1_display", int'(o_oe_n == 1'b0 && o_row_addr == 1'b1), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("async_rst_oe_n", int'(o_oe_n), 1);
        chk_eq("async_rst_busy", int'(o_busy), 0);
        chk_eq("async_rst_row_addr", int'(o_row_addr), 0);
        chk_eq("async_rst_init_addr", int'(o_init_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n0 = start_addr_log.size();
        wait_starts(n0 + 1);
        if (start_addr_log.size() > n0) begin
            chk_eq("post_rst_addr", start_addr_log[n0], 0);
            chk_eq("post_rst_bit", start_bit_log[n0], 0);
        end
        i_enable = 1'b0;
        t = 0;
        while (o_busy && t < 800) begin
            @(negedge clk);
            t++;
        end
        chk_eq("final_idle", int'(o_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Upstream sequencer for hub75_color_tx.
- Walks every row pair and bit plane of a frame and starts one row shift per bit plane, supplying the row's start address and bit index.
- Drives panel row address and active-low output enable with binary-coded modulation (BCM) weighting: the display time of bit b is proportional to 2^b.
- Shifting and display are strictly sequential. OE stays off while shifting and while the row address changes.

Parameters:
- hpixel_p, 64, display width in pixels.
- vpixel_p, 64, display height in pixels.
- bpp_p, 8, bits per colour channel (number of bit planes).
- segments_p, 2, display segments driven in parallel.
- blank_cycles_p, 4, OE-off cycles between latch completion and display start.
- Localparams:
  - rows_p = vpixel_p/segments_p
  - row_w_p = $clog2(rows_p)
  - addr_width_p = $clog2(hpixel_p*vpixel_p)
  - pix_bit_width_p = $clog2(bpp_p)
  - disp_w_p = 8+bpp_p

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_enable  in  1  run frames continuously while high.
- i_oe_base  in  8  BCM base unit; display cycles for bit b = (i_oe_base+1)<<b.
- o_tx_start  out  1  start pulse to hub75_color_tx.
- o_init_addr  out  addr_width_p  row start address = row*hpixel_p.
- o_pix_bit  out  pix_bit_width_p  bit plane to shift.
- i_tx_ready  in  1  hub75_color_tx o_ready.
- o_row_addr  out  row_w_p  panel row select (A..E).
- o_oe_n  out  1  panel output enable, active-low.
- o_frame_done  out  1  one-cycle pulse after the last plane of the last row.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs registered.
- Reset values: o_tx_start=0, o_init_addr=0, o_pix_bit=0, o_row_addr=0, o_oe_n=1, o_frame_done=0, o_busy=0. Internal row_cnt=0, bit_cnt=0, state=IDLE.
- Reset mid-operation: outputs take their reset values immediately with no clock edge. This blanks the panel. After release the block restarts at row 0, bit 0.
- IDLE:
  - Leave when i_enable=1 and i_tx_ready=1.
  - On exit: sample i_oe_base into oe_base_q, clear row_cnt and bit_cnt, go to START.
- START:
  - o_tx_start=1 for exactly one cycle.
  - o_init_addr=row_cnt*hpixel_p and o_pix_bit=bit_cnt, both stable from this cycle until WAIT_DONE exits.
  - Go to WAIT_ACK.
- WAIT_ACK: o_tx_start=0. Wait for i_tx_ready=0, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for i_tx_ready=1 (shift plus latch complete).
  - No timeout; a stalled tx holds this state with o_oe_n=1.
- BLANK:
  - On entry, o_row_addr <= row_cnt.
  - o_oe_n=1 for blank_cycles_p cycles, then go to DISPLAY.
- DISPLAY:
  - o_oe_n=0 for exactly (oe_base_q+1)<<bit_cnt cycles. Counter width disp_w_p, no overflow.
  - Then o_oe_n=1 and go to NEXT.
- NEXT (1 cycle), advance counters:
  - If bit_cnt<bpp_p-1: bit_cnt++.
  - Else bit_cnt=0 and row_cnt++.
  - If row_cnt wraps from rows_p-1: row_cnt=0, o_frame_done=1 for this cycle, oe_base_q re-sampled from i_oe_base.
- Leaving NEXT:
  - Go to START if i_enable=1.
  - Go to IDLE if i_enable=0 and the frame just completed.
  - Otherwise (disabled mid-frame) go to START; the frame always completes.
- i_oe_base changes take effect only at frame boundaries.
- o_oe_n=0 only in DISPLAY.
- o_row_addr never changes while o_oe_n=0.

Decomposition:
- Shared package hub75_pkg holds:
  - the scan_state_t enum (IDLE, START, WAIT_ACK, WAIT_DONE, BLANK, DISPLAY, NEXT)
  - the default blank_cycles constant
  - the width helper functions
- Sub-module hub75_bcm_timer:
  - load of (base+1)<<bit, down-count, done flag.
  - Reused for the BLANK countdown via a separate load value.

Test Plan:
Params for all scenarios: hpixel 4, vpixel 4, bpp 2, segments 2 (rows_p=2), blank 4. Bench includes a behavioural tx model.
1. Reset: rst_n=0 -> o_oe_n=1, o_tx_start=0, o_row_addr=0, o_busy=0, o_frame_done=0.
2. i_enable=1, i_oe_base=3, tx ready:
   - first start pulse is 1 cycle with addr 0, bit 0; after tx done, 4 blank cycles then o_oe_n low 4 cycles;
   - next start has bit 1; o_oe_n low 8 cycles.
3. Row advance:
   - third start has addr 4, bit 0;
   - o_row_addr goes 0->1 on BLANK entry with o_oe_n=1.
4. Frame wrap:
   - o_frame_done pulses once after row1/bit1 display; next start has addr 0.
   - i_oe_base changed to 0 mid-frame -> the old weight holds until the wrap, then bit0 display lasts 1 cycle.
5. i_enable dropped during row0 -> frame finishes (4 planes total), frame_done pulses, IDLE, o_busy=0, no further starts.
6. Async reset during DISPLAY -> o_oe_n=1 before the next clk edge; after release, first start has addr 0, bit 0.
